// File: rtl/risc_pkg.sv
// Shared load/store types: LSU state encoding, byte-enable masks, access
// sizes and the alignment rule for a memory access.
package risc_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_WAIT_ACK,
        LSU_DONE
    } lsu_state_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    // Size 2'b10 has no meaning and is always rejected.
    function automatic logic lsu_access_legal(input logic [1:0] size, input logic [1:0] addrLo);
        logic legal;
        case (size)
            SIZE_BYTE: legal = 1'b1;
            SIZE_HALF: legal = ~addrLo[0];
            SIZE_WORD: legal = (addrLo == 2'b00);
            default:   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load alignment: shifts the addressed lane of the read word down to bit 0
// and zero- or sign-extends byte and halfword loads.
module lsu_load_align
    import risc_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addrLo,
    input  logic [1:0]  i_size,
    input  logic        i_zext,
    output logic [31:0] o_loadData
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_addrLo, 3'b000};

    always_comb begin
        o_loadData = i_rdata;
        case (i_size)
            SIZE_BYTE: o_loadData = i_zext ? {24'b0, w_shifted[7:0]}
                                           : {{24{w_shifted[7]}}, w_shifted[7:0]};
            SIZE_HALF: o_loadData = i_zext ? {16'b0, w_shifted[15:0]}
                                           : {{16{w_shifted[15]}}, w_shifted[15:0]};
            default:   o_loadData = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_interface.sv
// Load/store unit: steers store lanes, drives a req/ack data-memory port,
// aligns load data and stalls the core until the access completes or aborts.
module lsu_mem_interface
    import risc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_mem_valid,
    input  logic        ctrl_mem_write,
    input  logic [1:0]  ctrl_mem_size,
    input  logic        ctrl_load_zext,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        misalign_err,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t r_state;
    lsu_state_t w_nextState;

    logic [CNT_W-1:0] r_waitCnt;
    logic [1:0]       r_addrLo;
    logic [1:0]       r_size;
    logic             r_zext;

    logic        w_legal;
    logic        w_timeout;
    logic [3:0]  w_steerBe;
    logic [31:0] w_steerData;
    logic [31:0] w_alignedLoad;

    assign w_legal   = lsu_access_legal(ctrl_mem_size, addr[1:0]);
    // Counter is loaded with 1 on entry, so it equals the WAIT_ACK cycle number.
    assign w_timeout = (r_waitCnt == CNT_W'(TIMEOUT_CYCLES));

    lsu_load_align u_loadAlign (
        .i_rdata    (dmem_rdata),
        .i_addrLo   (r_addrLo),
        .i_size     (r_size),
        .i_zext     (r_zext),
        .o_loadData (w_alignedLoad)
    );

    always_comb begin
        w_steerBe   = BE_WORD;
        w_steerData = store_data;
        case (ctrl_mem_size)
            SIZE_BYTE: begin
                w_steerBe   = BE_BYTE << addr[1:0];
                w_steerData = {4{store_data[7:0]}};
            end
            SIZE_HALF: begin
                w_steerBe   = addr[1] ? (BE_HALF << 2) : BE_HALF;
                w_steerData = {2{store_data[15:0]}};
            end
            default: begin
                w_steerBe   = BE_WORD;
                w_steerData = store_data;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= LSU_IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            LSU_IDLE:     if (ctrl_mem_valid) w_nextState = w_legal ? LSU_WAIT_ACK : LSU_DONE;
            LSU_WAIT_ACK: if (dmem_ack || w_timeout) w_nextState = LSU_DONE;
            LSU_DONE:     w_nextState = LSU_IDLE;
            default:      w_nextState = LSU_IDLE;
        endcase
    end

    always_comb begin
        lsu_stall = 1'b0;
        lsu_done  = 1'b0;
        case (r_state)
            LSU_IDLE:     lsu_stall = ctrl_mem_valid;
            LSU_WAIT_ACK: lsu_stall = 1'b1;
            LSU_DONE:     lsu_done  = 1'b1;
            default:      lsu_stall = 1'b0;
        endcase
    end

    // Error flags are set only on the edge into DONE, so they pulse with lsu_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_data    <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            r_waitCnt    <= '0;
            r_addrLo     <= '0;
            r_size       <= '0;
            r_zext       <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (r_state)
                LSU_IDLE: begin
                    if (ctrl_mem_valid && w_legal) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= ctrl_mem_write;
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_be    <= w_steerBe;
                        dmem_wdata <= ctrl_mem_write ? w_steerData : 32'b0;
                        r_waitCnt  <= CNT_W'(1);
                        r_addrLo   <= addr[1:0];
                        r_size     <= ctrl_mem_size;
                        r_zext     <= ctrl_load_zext;
                    end else if (ctrl_mem_valid) begin
                        misalign_err <= 1'b1;
                        load_data    <= '0;
                    end
                end
                LSU_WAIT_ACK: begin
                    if (dmem_ack) begin
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        r_waitCnt <= '0;
                        if (!dmem_we) load_data <= w_alignedLoad;
                    end else if (w_timeout) begin
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        bus_err   <= 1'b1;
                        load_data <= '0;
                        r_waitCnt <= '0;
                    end else begin
                        r_waitCnt <= r_waitCnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_interface.sv
// Directed testbench for lsu_mem_interface with a four-cycle ack timeout;
// a bench-side memory model answers requests after a chosen delay.
module tb_lsu_mem_interface;

    logic        clk = 1'b0;
    logic        rst;
    logic        ctrl_mem_valid;
    logic        ctrl_mem_write;
    logic [1:0]  ctrl_mem_size;
    logic        ctrl_load_zext;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        lsu_stall;
    logic        lsu_done;
    logic        misalign_err;
    logic        bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    int checks = 0;
    int failures = 0;

    int          stallCycles, reqCycles, doneCycle;
    logic        gotDone, doneReq, doneMis, doneBus, capWe;
    logic [31:0] capAddr, capWdata, doneLoad;
    logic [3:0]  capBe;

    lsu_mem_interface #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl_mem_valid (ctrl_mem_valid),
        .ctrl_mem_write (ctrl_mem_write),
        .ctrl_mem_size  (ctrl_mem_size),
        .ctrl_load_zext (ctrl_load_zext),
        .addr           (addr),
        .store_data     (store_data),
        .load_data      (load_data),
        .lsu_stall      (lsu_stall),
        .lsu_done       (lsu_done),
        .misalign_err   (misalign_err),
        .bus_err        (bus_err),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata)
    );

    always #5 clk = ~clk;

    // Presents one instruction from the next negedge and records what the DUT does
    // until lsu_done; ackDelay < 0 means memory never acknowledges.
    task automatic do_access(input logic we, input logic [1:0] size, input logic zext,
                             input logic [31:0] a, input logic [31:0] sd,
                             input logic [31:0] rd, input int ackDelay);
        stallCycles = 0; reqCycles = 0; doneCycle = -1; gotDone = 1'b0;
        doneReq = 1'bx; doneMis = 1'bx; doneBus = 1'bx; doneLoad = 'x;
        capWe = 1'bx; capAddr = 'x; capWdata = 'x; capBe = 'x;
        @(negedge clk);
        ctrl_mem_write = we; ctrl_mem_size = size; ctrl_load_zext = zext;
        addr = a; store_data = sd; ctrl_mem_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (lsu_done) begin
                gotDone = 1'b1; doneCycle = c; doneReq = dmem_req;
                doneMis = misalign_err; doneBus = bus_err; doneLoad = load_data;
                break;
            end
            if (lsu_stall) stallCycles++;
            if (dmem_req) begin
                if (reqCycles == 0) begin
                    capWe = dmem_we; capAddr = dmem_addr; capBe = dmem_be; capWdata = dmem_wdata;
                end
                reqCycles++;
                if (ackDelay >= 0 && reqCycles == ackDelay + 1) begin
                    dmem_ack = 1'b1; dmem_rdata = rd;
                end
            end
            @(negedge clk);
            dmem_ack = 1'b0;
        end
        ctrl_mem_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; ctrl_mem_valid = 1'b0; ctrl_mem_write = 1'b0; ctrl_mem_size = 2'b00;
        ctrl_load_zext = 1'b0; addr = '0; store_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== 70'b0) begin failures++;
            $display("[TB] FAIL reset_dmem: got req=%b we=%b be=%b addr=%h wdata=%h expected all 0", dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata); end
        checks++; if (load_data !== 32'h0) begin failures++;
            $display("[TB] FAIL reset_load_data: got %h expected 00000000", load_data); end
        checks++; if ({lsu_stall, lsu_done, misalign_err, bus_err} !== 4'b0) begin failures++;
            $display("[TB] FAIL reset_status: got stall/done/mis/bus=%b expected 0000", {lsu_stall, lsu_done, misalign_err, bus_err}); end
    endtask

    task automatic test_store_word;
        do_access(1'b1, 2'b11, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 2);
        checks++; if (gotDone !== 1'b1 || doneCycle != 4) begin failures++;
            $display("[TB] FAIL sw_done_cycle: got done=%b cycle=%0d expected 1 cycle=4", gotDone, doneCycle); end
        checks++; if ({capWe, capBe, capAddr} !== {1'b1, 4'b1111, 32'h100}) begin failures++;
            $display("[TB] FAIL sw_request: got we=%b be=%b addr=%h expected we=1 be=1111 addr=00000100", capWe, capBe, capAddr); end
        checks++; if (capWdata !== 32'hDEADBEEF) begin failures++;
            $display("[TB] FAIL sw_wdata: got %h expected deadbeef", capWdata); end
        checks++; if (stallCycles != 4) begin failures++;
            $display("[TB] FAIL sw_stall: got %0d cycles expected 4", stallCycles); end
        checks++; if ({doneReq, doneMis, doneBus} !== 3'b000) begin failures++;
            $display("[TB] FAIL sw_flags: got req/mis/bus=%b expected 000", {doneReq, doneMis, doneBus}); end
    endtask

    task automatic test_load_byte;
        do_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80FF_0000, 0);
        checks++; if (doneLoad !== 32'hFFFFFF80) begin failures++;
            $display("[TB] FAIL lb_data: got %h expected ffffff80", doneLoad); end
        checks++; if ({capWe, capBe, capAddr} !== {1'b0, 4'b1000, 32'h100}) begin failures++;
            $display("[TB] FAIL lb_request: got we=%b be=%b addr=%h expected we=0 be=1000 addr=00000100", capWe, capBe, capAddr); end
        checks++; if (stallCycles != 2 || doneCycle != 2) begin failures++;
            $display("[TB] FAIL lb_latency: got stall=%0d done_cycle=%0d expected 2 and 2", stallCycles, doneCycle); end
        do_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80FF_0000, 0);
        checks++; if (doneLoad !== 32'h00000080) begin failures++;
            $display("[TB] FAIL lbu_data: got %h expected 00000080", doneLoad); end
    endtask

    task automatic test_halfword;
        do_access(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'h8001_1234, 1);
        checks++; if (doneLoad !== 32'hFFFF8001) begin failures++;
            $display("[TB] FAIL lh_data: got %h expected ffff8001", doneLoad); end
        checks++; if (stallCycles != 3) begin failures++;
            $display("[TB] FAIL lh_stall: got %0d cycles expected 3", stallCycles); end
        do_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_ABCD, 32'h0, 0);
        checks++; if ({capWe, capBe} !== {1'b1, 4'b1100}) begin failures++;
            $display("[TB] FAIL sh_be: got we=%b be=%b expected we=1 be=1100", capWe, capBe); end
        checks++; if (capWdata !== 32'hABCDABCD) begin failures++;
            $display("[TB] FAIL sh_wdata: got %h expected abcdabcd", capWdata); end
        checks++; if (doneLoad !== 32'hFFFF8001) begin failures++;
            $display("[TB] FAIL sh_load_kept: got %h expected ffff8001", doneLoad); end
    endtask

    task automatic test_misaligned;
        do_access(1'b0, 2'b11, 1'b0, 32'h101, 32'h0, 32'h0, 0);
        checks++; if (reqCycles != 0 || doneCycle != 1) begin failures++;
            $display("[TB] FAIL lw_mis_timing: got req_cycles=%0d done_cycle=%0d expected 0 and 1", reqCycles, doneCycle); end
        checks++; if ({doneMis, doneBus} !== 2'b10 || doneLoad !== 32'h0) begin failures++;
            $display("[TB] FAIL lw_mis_flags: got mis/bus=%b load=%h expected 10 and 00000000", {doneMis, doneBus}, doneLoad); end
        do_access(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 32'h0055_0000, 0);
        do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'h0, 0);
        checks++; if (reqCycles != 0 || doneMis !== 1'b1 || doneLoad !== 32'h0) begin failures++;
            $display("[TB] FAIL size10_mis: got req_cycles=%0d mis=%b load=%h expected 0 1 00000000", reqCycles, doneMis, doneLoad); end
        do_access(1'b1, 2'b01, 1'b0, 32'h201, 32'h1234, 32'h0, 0);
        checks++; if (reqCycles != 0 || doneMis !== 1'b1 || stallCycles != 1) begin failures++;
            $display("[TB] FAIL sh_odd_mis: got req_cycles=%0d mis=%b stall=%0d expected 0 1 1", reqCycles, doneMis, stallCycles); end
    endtask

    task automatic test_timeout;
        do_access(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h1122_3344, 0);
        do_access(1'b0, 2'b11, 1'b0, 32'h300, 32'h0, 32'h0, -1);
        checks++; if (reqCycles != 4 || doneCycle != 5) begin failures++;
            $display("[TB] FAIL timeout_req_cycles: got req=%0d done_cycle=%0d expected 4 and 5", reqCycles, doneCycle); end
        checks++; if ({doneBus, doneMis, doneReq} !== 3'b100 || doneLoad !== 32'h0) begin failures++;
            $display("[TB] FAIL timeout_flags: got bus/mis/req=%b load=%h expected 100 and 00000000", {doneBus, doneMis, doneReq}, doneLoad); end
    endtask

    task automatic test_ack_ignored;
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        checks++; if ({lsu_stall, lsu_done, dmem_req, bus_err} !== 4'b0000) begin failures++;
            $display("[TB] FAIL stray_ack: got stall/done/req/bus=%b expected 0000", {lsu_stall, lsu_done, dmem_req, bus_err}); end
    endtask

    task automatic test_reset_mid_access;
        logic sawDone;
        sawDone = 1'b0;
        @(negedge clk);
        ctrl_mem_write = 1'b0; ctrl_mem_size = 2'b11; ctrl_load_zext = 1'b0;
        addr = 32'h400; ctrl_mem_valid = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (dmem_req !== 1'b1) begin failures++;
            $display("[TB] FAIL mid_req_up: got %b expected 1", dmem_req); end
        rst = 1'b1; ctrl_mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        #1;
        checks++; if ({dmem_req, lsu_done, lsu_stall} !== 3'b000) begin failures++;
            $display("[TB] FAIL mid_after_rst: got req/done/stall=%b expected 000", {dmem_req, lsu_done, lsu_stall}); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            dmem_ack = 1'b0;
            #1;
            if (lsu_done) sawDone = 1'b1;
        end
        checks++; if (sawDone !== 1'b0 || load_data !== 32'h0) begin failures++;
            $display("[TB] FAIL mid_late_ack: got done_seen=%b load=%h expected 0 and 00000000", sawDone, load_data); end
        do_access(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 0);
        checks++; if (doneLoad !== 32'h12345678 || stallCycles != 2 || {doneMis, doneBus} !== 2'b00) begin failures++;
            $display("[TB] FAIL mid_recover_lw: got load=%h stall=%0d mis/bus=%b expected 12345678 2 00", doneLoad, stallCycles, {doneMis, doneBus}); end
    endtask

    task automatic test_back_to_back;
        do_access(1'b1, 2'b00, 1'b0, 32'h101, 32'h0000_005A, 32'h0, 0);
        checks++; if ({capBe, capWdata} !== {4'b0010, 32'h5A5A5A5A}) begin failures++;
            $display("[TB] FAIL b2b_sb: got be=%b wdata=%h expected 0010 5a5a5a5a", capBe, capWdata); end
        do_access(1'b0, 2'b01, 1'b1, 32'h206, 32'h0, 32'hF00D_0000, 1);
        checks++; if (doneLoad !== 32'h0000F00D || doneCycle != 3 || capAddr !== 32'h204) begin failures++;
            $display("[TB] FAIL b2b_lhu: got load=%h done_cycle=%0d addr=%h expected 0000f00d 3 00000204", doneLoad, doneCycle, capAddr); end
        do_access(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'h0000_00FE, 0);
        checks++; if (doneLoad !== 32'hFFFFFFFE || capBe !== 4'b0001) begin failures++;
            $display("[TB] FAIL b2b_lb: got load=%h be=%b expected fffffffe 0001", doneLoad, capBe); end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_halfword();
        test_misaligned();
        test_timeout();
        test_ack_ignored();
        test_reset_mid_access();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
